i2c_slave_target: RTL and testbench



---
 rtl/i2c_slave_target.sv | 269 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_target.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_target.sv
// I2C target endpoint: oversampled sclk/sda, START/STOP detection, 7-bit
// address match, byte write delivery and byte read serialisation.
// Optional build macro I2C_GLITCH_FILTER_EN inserts a 3-sample majority
// filter on both bus lines after the synchronisers (adds 2 clk latency).
module i2c_slave_target #(
  parameter logic [6:0] i2c_slave_address = 7'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_WRITE     = 4'd3,
    ST_WRITE_ACK = 4'd4,
    ST_READ      = 4'd5,
    ST_READ_ACK  = 4'd6,
    ST_IGNORE    = 4'd7
  } state_t;

  // Input path registers; idle bus level is high on both lines.
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic sclk_cur, sda_cur;

  // Two-flop synchronisers on both bus lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta_q <= 1'b1;
      sclk_sync_q <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
    end else begin
      sclk_meta_q <= sclk;
      sclk_sync_q <= sclk_meta_q;
      sda_meta_q  <= sda;
      sda_sync_q  <= sda_meta_q;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic sclk_h1_q, sclk_h2_q, sclk_filt_q;
  logic sda_h1_q, sda_h2_q, sda_filt_q;

  // Majority of three consecutive synchronised samples; a single-clk pulse
  // never wins the vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_h1_q   <= 1'b1;
      sclk_h2_q   <= 1'b1;
      sclk_filt_q <= 1'b1;
      sda_h1_q    <= 1'b1;
      sda_h2_q    <= 1'b1;
      sda_filt_q  <= 1'b1;
    end else begin
      sclk_h1_q   <= sclk_sync_q;
      sclk_h2_q   <= sclk_h1_q;
      sclk_filt_q <= (sclk_sync_q & sclk_h1_q) | (sclk_sync_q & sclk_h2_q) | (sclk_h1_q & sclk_h2_q);
      sda_h1_q    <= sda_sync_q;
      sda_h2_q    <= sda_h1_q;
      sda_filt_q  <= (sda_sync_q & sda_h1_q) | (sda_sync_q & sda_h2_q) | (sda_h1_q & sda_h2_q);
    end
  end

  assign sclk_cur = sclk_filt_q;
  assign sda_cur  = sda_filt_q;
`else
  assign sclk_cur = sclk_sync_q;
  assign sda_cur  = sda_sync_q;
`endif

  // Previous-sample registers used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b1;
      sda_prev_q  <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_cur;
      sda_prev_q  <= sda_cur;
    end
  end

  logic sclk_rise, sclk_fall, start_det, stop_det;
  assign sclk_rise = sclk_cur & ~sclk_prev_q;
  assign sclk_fall = ~sclk_cur & sclk_prev_q;
  // Only a data transition during a stable high clock is a bus condition.
  assign start_det = sclk_cur & sclk_prev_q & sda_prev_q & ~sda_cur;
  assign stop_det  = sclk_cur & sclk_prev_q & ~sda_prev_q & sda_cur;

  // Protocol state
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       addr_match;

  // General call (address 0) is never claimed even if configured.
  assign addr_match = (shift_q[7:1] == i2c_slave_address) && (shift_q[7:1] != 7'd0);

  // State and datapath registers; reset releases sda immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: START/STOP override everything, otherwise bits are
  // sampled on sclk rise and sda is only changed on sclk fall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;

    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d = 1'b0;
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            shift_d = {shift_q[6:0], sda_cur};
            cnt_d   = cnt_q + 4'd1;
          end else if (sclk_fall && cnt_q == 4'd8) begin
            rw_d  = shift_q[0];
            cnt_d = 4'd0;
            if (addr_match) begin
              oe_d    = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              oe_d    = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (sclk_rise) begin
            // Give local logic the whole high phase to present tx_data.
            tx_req_d = rw_q;
          end else if (sclk_fall) begin
            if (rw_q) begin
              shift_d = tx_data;
              oe_d    = ~tx_data[7];
              cnt_d   = 4'd1;
              state_d = ST_READ;
            end else begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (sclk_rise) begin
            shift_d = {shift_q[6:0], sda_cur};
            cnt_d   = cnt_q + 4'd1;
          end else if (sclk_fall && cnt_q == 4'd8) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            oe_d       = 1'b1;
            cnt_d      = 4'd0;
            state_d    = ST_WRITE_ACK;
          end
        end
        ST_WRITE_ACK: begin
          if (sclk_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = ST_WRITE;
          end
        end
        ST_READ: begin
          // cnt_q counts bits already placed on the bus.
          if (sclk_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = ST_READ_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        ST_READ_ACK: begin
          if (sclk_rise) begin
            if (!sda_cur) begin
              tx_req_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = ST_IGNORE;
            end
          end else if (sclk_fall) begin
            // Still here on the fall means the master acknowledged.
            shift_d = tx_data;
            oe_d    = ~tx_data[7];
            cnt_d   = 4'd1;
            state_d = ST_READ;
          end
        end
        ST_IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Open-drain: pull low or release, never drive high.
  assign sda      = oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: behavioural I2C master on the bus, queue-based
// monitor of rx_valid/tx_req, and a simple transaction-level reference model.
module tb_i2c_slave_target;

  localparam logic [6:0] ADDR = 7'h01;
  localparam int HALF = 12;
  localparam int Q    = 6;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       m_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic [3:0] state;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_target #(.i2c_slave_address(ADDR)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .sda      (sda),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .busy     (busy),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int overlap_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] wbuf[4];
  logic [7:0] txbuf[4];
  logic [7:0] rbuf[4];

  // Monitor of the local-side pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        rx_cnt <= rx_cnt + 1;
      end
      if (tx_req) tx_cnt <= tx_cnt + 1;
      if (rx_valid && tx_req) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // ---------------- master bus primitives ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_clk(Q); m_low = 1'b0;
    wait_clk(Q); sclk = 1'b1;
    wait_clk(HALF); m_low = 1'b1;
    wait_clk(HALF); sclk = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); m_low = 1'b1;
    wait_clk(Q); sclk = 1'b1;
    wait_clk(HALF); m_low = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(Q); m_low = ~b;
    wait_clk(Q); sclk = 1'b1;
    wait_clk(HALF); sclk = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(Q); m_low = 1'b0;
    wait_clk(Q); sclk = 1'b1;
    wait_clk(Q); b = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_clk(Q); sclk = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
  endtask

  task automatic master_write(input logic [6:0] a, input int n, output logic aack, output logic [3:0] dacks);
    logic k;
    dacks = 4'hF;
    write_byte({a, 1'b0}, aack);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], k);
      dacks[i] = k;
    end
  endtask

  task automatic master_read(input logic [6:0] a, input int n, output logic aack);
    tx_data = txbuf[0];
    write_byte({a, 1'b1}, aack);
    for (int i = 0; i < n; i++) begin
      read_byte(rbuf[i]);
      if (i < n - 1) begin
        tx_data = txbuf[i + 1];
        write_bit(1'b0);
      end else begin
        write_bit(1'b1);
      end
    end
  endtask

  task automatic bus_recover();
    wait_clk(2); rst = 1'b0;
    m_low = 1'b0;
    wait_clk(Q); sclk = 1'b1;
    wait_clk(HALF);
  endtask

  // ---------------- reference model ----------------
  function automatic logic exp_claims(input logic [6:0] a);
    return (a == ADDR) && (a != 7'd0);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; sclk = 1'b1; m_low = 1'b0; tx_data = 8'h00;
    wait_clk(4);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0 || tx_req !== 1'b0) begin errors++; $display("FAIL reset_pulses: got rx_valid=%b tx_req=%b expected 0 0", rx_valid, tx_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1 (released)", sda); end
    rst = 1'b0;
    wait_clk(HALF);
    $display("txn reset: outputs checked");
  endtask

  task automatic test_write();
    logic aack; logic [3:0] dacks; int rx0;
    rx0 = rx_cnt;
    wbuf[0] = 8'hA5;
    i2c_start();
    master_write(ADDR, 1, aack, dacks);
    wait_clk(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_mid: got %b expected 1", busy); end
    i2c_stop();
    wait_clk(6);
    checks++; if (aack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b expected 0", aack); end
    checks++; if (dacks[0] !== 1'b0) begin errors++; $display("FAIL wr_data_ack: got %b expected 0", dacks[0]); end
    checks++; if (rx_cnt - rx0 !== 1) begin errors++; $display("FAIL wr_rx_valid_count: got %0d expected 1", rx_cnt - rx0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL wr_rx_data: got %h expected a5", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b expected 0", busy); end
    $display("txn write: addr=%h data=a5 rx_data=%h", ADDR, rx_data);
  endtask

  task automatic test_read();
    logic aack; int tx0;
    tx0 = tx_cnt;
    txbuf[0] = 8'h3C;
    i2c_start();
    master_read(ADDR, 1, aack);
    wait_clk(2);
    checks++; if (state !== 4'd7) begin errors++; $display("FAIL rd_state_after_nack: got %0d expected 7", state); end
    i2c_stop();
    wait_clk(6);
    checks++; if (aack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b expected 0", aack); end
    checks++; if (rbuf[0] !== 8'h3C) begin errors++; $display("FAIL rd_byte: got %h expected 3c", rbuf[0]); end
    checks++; if (tx_cnt - tx0 !== 1) begin errors++; $display("FAIL rd_tx_req_count: got %0d expected 1", tx_cnt - tx0); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rd_state_after_stop: got %0d expected 0", state); end
    $display("txn read: addr=%h byte=%h", ADDR, rbuf[0]);
  endtask

  task automatic test_multi_read();
    logic aack; int tx0;
    tx0 = tx_cnt;
    txbuf[0] = 8'h81; txbuf[1] = 8'h7E;
    i2c_start();
    master_read(ADDR, 2, aack);
    i2c_stop();
    wait_clk(6);
    checks++; if (rbuf[0] !== 8'h81 || rbuf[1] !== 8'h7E) begin errors++; $display("FAIL mrd_bytes: got %h %h expected 81 7e", rbuf[0], rbuf[1]); end
    checks++; if (tx_cnt - tx0 !== 2) begin errors++; $display("FAIL mrd_tx_req_count: got %0d expected 2", tx_cnt - tx0); end
    $display("txn multi-read: bytes=%h %h", rbuf[0], rbuf[1]);
  endtask

  task automatic test_mismatch();
    logic aack; logic [3:0] dacks; int rx0;
    rx0 = rx_cnt;
    wbuf[0] = 8'hFF;
    i2c_start();
    master_write(7'h22, 1, aack, dacks);
    wait_clk(2);
    checks++; if (state !== 4'd7) begin errors++; $display("FAIL mis_state: got %0d expected 7", state); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mis_busy: got %b expected 1", busy); end
    i2c_stop();
    wait_clk(6);
    checks++; if (aack !== 1'b1 || dacks[0] !== 1'b1) begin errors++; $display("FAIL mis_acks: got %b %b expected 1 1", aack, dacks[0]); end
    checks++; if (rx_cnt !== rx0) begin errors++; $display("FAIL mis_rx_valid: got %0d pulses expected 0", rx_cnt - rx0); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL mis_state_after_stop: got %0d expected 0", state); end
    $display("txn mismatch: addr=22 ignored");
  endtask

  task automatic test_repeated_start();
    logic aack; logic [3:0] dacks;
    wbuf[0] = 8'h10;
    txbuf[0] = 8'($urandom_range(0, 255));
    i2c_start();
    master_write(ADDR, 1, aack, dacks);
    i2c_start();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL rs_state: got %0d expected 1", state); end
    master_read(ADDR, 1, aack);
    i2c_stop();
    wait_clk(6);
    checks++; if (rx_data !== 8'h10) begin errors++; $display("FAIL rs_rx_data: got %h expected 10", rx_data); end
    checks++; if (aack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b expected 0", aack); end
    checks++; if (rbuf[0] !== txbuf[0]) begin errors++; $display("FAIL rs_read_byte: got %h expected %h", rbuf[0], txbuf[0]); end
    $display("txn repeated-start: wrote 10 read %h", rbuf[0]);
  endtask

  task automatic test_reset_midbyte();
    logic aack; logic [3:0] dacks;
    // Reset after four data bits of a write.
    i2c_start();
    write_byte({ADDR, 1'b0}, aack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    rst = 1'b1;
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstm_sda: got %b expected 1", sda); end
    checks++; if (rx_data !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rstm_outputs: got rx_data=%h busy=%b expected 00 0", rx_data, busy); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rstm_state: got %0d expected 0", state); end
    bus_recover();
    // Reset while the target is holding the address ACK.
    i2c_start();
    for (int i = 7; i >= 1; i--) write_bit(ADDR[i - 1]);
    write_bit(1'b0);
    wait_clk(Q); m_low = 1'b0;
    wait_clk(2);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rsta_ack_held: got %b expected 0", sda); end
    rst = 1'b1;
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rsta_sda_release: got %b expected 1", sda); end
    bus_recover();
    wbuf[0] = 8'h5A;
    i2c_start();
    master_write(ADDR, 1, aack, dacks);
    i2c_stop();
    wait_clk(6);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL rstm_recover: got %h expected 5a", rx_data); end
    $display("txn reset-midbyte: recovered rx_data=%h", rx_data);
  endtask

  task automatic test_random();
    logic aack; logic [3:0] dacks; logic [6:0] a; logic rw, claim;
    int n, rx0, qs0, tx0;
    for (int t = 0; t < 12; t++) begin
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = ADDR;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == ADDR) a = 7'h00;
      end
      n = $urandom_range(1, 3);
      claim = exp_claims(a);
      rx0 = rx_cnt; qs0 = rx_q.size(); tx0 = tx_cnt;
      for (int i = 0; i < 4; i++) begin
        wbuf[i] = 8'($urandom_range(0, 255));
        txbuf[i] = 8'($urandom_range(0, 255));
      end
      i2c_start();
      if (!rw) master_write(a, n, aack, dacks);
      else master_read(a, n, aack);
      i2c_stop();
      wait_clk(6);
      checks++; if (aack !== !claim) begin errors++; $display("FAIL rnd_addr_ack t%0d: got %b expected %b", t, aack, !claim); end
      if (!rw) begin
        for (int i = 0; i < n; i++) begin
          checks++; if (dacks[i] !== !claim) begin errors++; $display("FAIL rnd_data_ack t%0d b%0d: got %b expected %b", t, i, dacks[i], !claim); end
        end
        checks++; if (rx_cnt - rx0 !== (claim ? n : 0)) begin errors++; $display("FAIL rnd_rx_count t%0d: got %0d expected %0d", t, rx_cnt - rx0, claim ? n : 0); end
        if (claim && rx_q.size() >= qs0 + n) begin
          for (int i = 0; i < n; i++) begin
            checks++; if (rx_q[qs0 + i] !== wbuf[i]) begin errors++; $display("FAIL rnd_rx_data t%0d b%0d: got %h expected %h", t, i, rx_q[qs0 + i], wbuf[i]); end
          end
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++; if (rbuf[i] !== (claim ? txbuf[i] : 8'hFF)) begin errors++; $display("FAIL rnd_rd_data t%0d b%0d: got %h expected %h", t, i, rbuf[i], claim ? txbuf[i] : 8'hFF); end
        end
        checks++; if (tx_cnt - tx0 !== (claim ? n : 0)) begin errors++; $display("FAIL rnd_tx_count t%0d: got %0d expected %0d", t, tx_cnt - tx0, claim ? n : 0); end
      end
      checks++; if (state !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_idle t%0d: got state=%0d busy=%b expected 0 0", t, state, busy); end
      $display("txn random %0d: %s addr=%h n=%0d claimed=%b", t, rw ? "read " : "write", a, n, claim);
    end
  endtask

  task automatic test_no_overlap();
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d cycles expected 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_multi_read();
    test_mismatch();
    test_repeated_start();
    test_reset_midbyte();
    test_random();
    test_no_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
